// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I control sequencer; JAL support enabled by MC_CTRL_JAL_EN
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state_o,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state;

  // ALU operation for register and immediate arithmetic; sub only for R-type with funct7_5 set
  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // State register: memory states wait on mem_ready, TRAP holds until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:            state <= S_JAL;
`endif
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_MEMWB:    state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Datapath selects and strobes per state; strobes are suppressed while reset is held
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu(op, funct3, funct7_5);
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu(op, funct3, funct7_5);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        if (funct3 == 3'b000)      pc_write = zero;
        else if (funct3 == 3'b001) pc_write = ~zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  assign state_o = state;
  assign illegal = (state == S_TRAP);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm with a per-instruction reference model
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BRAN = 7'b1100011, JALOP = 7'b1101111, LUI = 7'b0110111;
`ifdef MC_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Intended arithmetic meaning of an instruction, as an ALU operation code
  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RTYPE && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; op = LOAD; funct3 = 3'b0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state_o, illegal} !== 5'b0000_0) begin
      errors++; $display("FAIL reset_state: got state=%0d illegal=%0b, want 0/0", state_o, illegal);
    end
    checks++;
    if ({mem_req, mem_we, ir_write, pc_write, reg_write} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b, want 00000", {mem_req, mem_we, ir_write, pc_write, reg_write});
    end
    checks++;
    if ({adr_src, alu_src_a, alu_src_b, result_src, alu_control} !== {1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
      errors++; $display("FAIL reset_selects: got %b, want 0001010000", {adr_src, alu_src_a, alu_src_b, result_src, alu_control});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from its first FETCH cycle; entered and left just after a falling edge
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input int w0, input int w1, input string nm);
    int  sq[$];
    bit  rq[$];
    bit  is_ld, is_st, is_r, is_i, is_b, is_j, is_trap, taken;
    int  n_ir = 0, n_pc = 0, n_rw = 0, n_req = 0, n_we = 0, n_adr = 0;
    logic [1:0] rs_seen = 2'b11;
    logic [1:0] want_imm;
    logic [2:0] want_alu;
    int  exp_pc, exp_rw, exp_req, exp_adr, exp_we;

    is_ld = (o == LOAD); is_st = (o == STORE); is_r = (o == RTYPE); is_i = (o == ITYPE);
    is_b = (o == BRAN); is_j = (o == JALOP) && JAL_EN;
    is_trap = !(is_ld || is_st || is_r || is_i || is_b || is_j);
    taken = is_b && ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z));
    want_alu = exp_alu(o, f3, f7);
    want_imm = (o == STORE) ? 2'b01 : (o == BRAN) ? 2'b10 : (o == JALOP) ? 2'b11 : 2'b00;

    for (int k = 0; k < w0; k++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    if (is_ld || is_st) begin
      sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < w1; k++) begin sq.push_back(is_st ? 5 : 3); rq.push_back(1'b0); end
      sq.push_back(is_st ? 5 : 3); rq.push_back(1'b1);
      if (is_ld) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_r || is_i) begin
      sq.push_back(is_r ? 6 : 7); rq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(8); rq.push_back(1'($urandom_range(0, 1)));
    end else if (is_b) begin
      sq.push_back(9); rq.push_back(1'($urandom_range(0, 1)));
    end else if (is_j) begin
      sq.push_back(10); rq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(8); rq.push_back(1'($urandom_range(0, 1)));
    end else begin
      sq.push_back(15); rq.push_back(1'($urandom_range(0, 1)));
    end

    op = o; funct3 = f3; funct7_5 = f7; zero = z;
    foreach (sq[i]) begin
      mem_ready = rq[i];
      #1;
      checks++;
      if (state_o !== 4'(sq[i])) begin
        errors++; $display("FAIL %s state[%0d]: got %0d, want %0d", nm, i, state_o, sq[i]);
      end
      checks++;
      if (imm_src !== want_imm) begin
        errors++; $display("FAIL %s imm_src[%0d]: got %b, want %b", nm, i, imm_src, want_imm);
      end
      n_ir += ir_write; n_pc += pc_write; n_rw += reg_write;
      n_req += mem_req; n_we += mem_we; n_adr += adr_src;
      if (reg_write) rs_seen = result_src;
      if (sq[i] == 0) begin
        checks++;
        if ({adr_src, alu_src_a, alu_src_b, result_src, alu_control} !== 10'b0_00_10_10_000) begin
          errors++; $display("FAIL %s fetch_sel: got %b, want 0001010000", nm, {adr_src, alu_src_a, alu_src_b, result_src, alu_control});
        end
      end
      if (sq[i] == 1 || sq[i] == 2 || sq[i] == 10) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_control} !== ((sq[i] == 1) ? 7'b01_01_000 : (sq[i] == 2) ? 7'b10_01_000 : 7'b01_10_000)) begin
          errors++; $display("FAIL %s alu_sel in state %0d: got %b", nm, sq[i], {alu_src_a, alu_src_b, alu_control});
        end
      end
      if (sq[i] == 6 || sq[i] == 7) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_control} !== {2'b10, (sq[i] == 6) ? 2'b00 : 2'b01, want_alu}) begin
          errors++; $display("FAIL %s exec_alu: got %b, want a=10 alu=%b", nm, {alu_src_a, alu_src_b, alu_control}, want_alu);
        end
      end
      if (sq[i] == 9) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_control, pc_write} !== {7'b10_00_001, taken}) begin
          errors++; $display("FAIL %s branch: got %b, want a=10 b=00 sub pc_write=%0b", nm, {alu_src_a, alu_src_b, alu_control, pc_write}, taken);
        end
      end
      @(posedge clk); @(negedge clk);
    end

    exp_pc  = 1 + (taken ? 1 : 0) + (is_j ? 1 : 0);
    exp_rw  = (is_ld || is_r || is_i || is_j) ? 1 : 0;
    exp_adr = (is_ld || is_st) ? w1 + 1 : 0;
    exp_req = w0 + 1 + exp_adr;
    exp_we  = is_st ? w1 + 1 : 0;
    checks++;
    if (n_ir !== 1 || n_pc !== exp_pc) begin
      errors++; $display("FAIL %s ir/pc_write counts: got %0d/%0d, want 1/%0d", nm, n_ir, n_pc, exp_pc);
    end
    checks++;
    if (n_rw !== exp_rw || (exp_rw == 1 && rs_seen !== (is_ld ? 2'b01 : 2'b00))) begin
      errors++; $display("FAIL %s reg_write: got count %0d src %b, want %0d", nm, n_rw, rs_seen, exp_rw);
    end
    checks++;
    if (n_req !== exp_req || n_adr !== exp_adr || n_we !== exp_we) begin
      errors++; $display("FAIL %s mem cycles req/adr/we: got %0d/%0d/%0d, want %0d/%0d/%0d",
                         nm, n_req, n_adr, n_we, exp_req, exp_adr, exp_we);
    end

    mem_ready = 1'b0;
    if (is_trap) begin
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (state_o !== 4'd15 || illegal !== 1'b1 || {mem_req, mem_we, ir_write, pc_write, reg_write} !== 5'b0) begin
          errors++; $display("FAIL %s trap_hold: got state=%0d illegal=%0b strobes=%b", nm, state_o, illegal,
                             {mem_req, mem_we, ir_write, pc_write, reg_write});
        end
        @(posedge clk); @(negedge clk);
      end
      rst_n = 1'b0; mem_ready = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'd0 || illegal !== 1'b0) begin
        errors++; $display("FAIL %s trap_clear: got state=%0d illegal=%0b, want 0/0", nm, state_o, illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      #1;
      checks++;
      if (state_o !== 4'd0 || illegal !== 1'b0) begin
        errors++; $display("FAIL %s return_fetch: got state=%0d illegal=%0b, want 0/0", nm, state_o, illegal);
      end
    end
  endtask

  task automatic test_lw();
    run_instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 0, "lw");
  endtask

  task automatic test_sw_wait();
    run_instr(STORE, 3'b010, 1'b0, 1'b0, 0, 3, "sw_wait");
  endtask

  task automatic test_sub();
    run_instr(RTYPE, 3'b000, 1'b1, 1'b0, 0, 0, "sub");
    run_instr(ITYPE, 3'b000, 1'b1, 1'b0, 1, 0, "addi_f7");
  endtask

  task automatic test_branch();
    run_instr(BRAN, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(BRAN, 3'b001, 1'b0, 1'b1, 0, 0, "bne_not_taken");
    run_instr(BRAN, 3'b100, 1'b0, 1'b1, 0, 0, "blt_unsupported");
    run_instr(BRAN, 3'b001, 1'b0, 1'b0, 2, 0, "bne_taken");
  endtask

  task automatic test_jal();
    run_instr(JALOP, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, "illegal_op");
  endtask

  task automatic test_reset_midwait();
    op = LOAD; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    checks++;
    if (state_o !== 4'd3 || mem_req !== 1'b1 || adr_src !== 1'b1) begin
      errors++; $display("FAIL midwait_setup: got state=%0d req=%0b adr=%0b, want 3/1/1", state_o, mem_req, adr_src);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, ir_write, pc_write, reg_write} !== 5'b0 || state_o !== 4'd0 || adr_src !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: got strobes=%b state=%0d adr=%0b, want 0/0/0",
                         {mem_req, mem_we, ir_write, pc_write, reg_write}, state_o, adr_src);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0 || mem_req !== 1'b1 || adr_src !== 1'b0 || ir_write !== 1'b0) begin
      errors++; $display("FAIL midwait_release: got state=%0d req=%0b adr=%0b ir=%0b, want 0/1/0/0", state_o, mem_req, adr_src, ir_write);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    logic [6:0] pool[7] = '{LOAD, STORE, RTYPE, ITYPE, BRAN, JALOP, LUI};
    for (int n = 0; n < 80; n++) begin
      run_instr(pool[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_sub();
    test_branch();
    test_jal();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle sequencer for the RV32I core. It replaces the single-cycle main decoder with a state machine that steps a shared datapath through fetch, decode, address generation, memory access, execute and writeback. The shared datapath has one unified memory port, one ALU and a register file. It sits between the instruction register / ALU flags and all datapath mux selects and write strobes, and handshakes with memory through a request/ready pair.

## Interface
Parameters:
- none (state and control encodings are fixed below)

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag, from the current-cycle ALU result
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register and OldPC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register file write enable
- result_src  out  2  result bus mux: 00 = ALUOut, 01 = mem data, 10 = ALU result
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  ALU B mux: 00 = rs2, 01 = imm, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- state_o  out  4  current state, for debug and verification
- illegal  out  1  unsupported opcode trapped; sticky until reset

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 15
- Transitions:
  - FETCH → DECODE on mem_ready; otherwise stay in FETCH.
  - DECODE branches on op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other opcode → TRAP
  - MEMADR → MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD → MEMWB on mem_ready. MEMWRITE → FETCH on mem_ready.
  - MEMWB → FETCH. EXECR and EXECI → ALUWB. ALUWB → FETCH. BRANCH → FETCH. JAL → ALUWB.
  - TRAP is terminal: all strobes are 0 and illegal = 1.
- Per-state outputs (any output not listed is 0):
  - FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, add, result_src = 10. ir_write and pc_write are asserted only in the cycle mem_ready = 1.
  - DECODE: a = 01, b = 01, add; computes the branch/jump target into ALUOut.
  - MEMADR: a = 10, b = 01, add.
  - MEMREAD: mem_req = 1, adr_src = 1.
  - MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1.
  - MEMWB: result_src = 01, reg_write = 1.
  - EXECR: a = 10, b = 00, funct-decoded ALU.
  - EXECI: a = 10, b = 01, funct-decoded ALU.
  - ALUWB: result_src = 00, reg_write = 1.
  - BRANCH: a = 10, b = 00, sub, result_src = 00. pc_write = zero when funct3 = 000, and !zero when funct3 = 001; any other funct3 is not taken.
  - JAL: a = 01, b = 10, add, result_src = 00, pc_write = 1. This stores PC+4 into ALUOut while PC takes the target.
- Funct decode, applied only in EXECR and EXECI:
  - funct3 000 → sub if {op[5], funct7_5} = 11, else add
  - funct3 010 → slt; 110 → or; 111 → and
  - any other funct3 → add
- imm_src is decoded combinationally from op in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.

## Timing
- state is registered; all outputs are combinational from state, op, funct3, funct7_5, zero and mem_ready.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4. Each wait cycle with mem_ready = 0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_req and adr_src/mem_we are held stable from the first request cycle through the mem_ready cycle.
- While rst_n = 0:
  - state = FETCH, illegal = 0.
  - mem_req, mem_we, ir_write, pc_write and reg_write are forced to 0.
  - Selects take their FETCH values: adr_src = 0, a = 00, b = 10, result_src = 10, alu_control = 000.
- Reset deasserted mid-instruction or mid-wait: the FSM restarts at FETCH and no partial write is issued.

## Configuration
- MC_CTRL_JAL_EN defined: the JAL state exists and opcode 1101111 is executed as described.
- MC_CTRL_JAL_EN undefined: opcode 1101111 → TRAP and illegal = 1. imm_src J-format decode remains.

## Test plan
- `lw` (0000011), mem_ready always 1 → state sequence 0, 1, 2, 3, 4, 0; reg_write = 1 only in state 4 with result_src = 01.
- `sw` with mem_ready low for 3 cycles in MEMWRITE → mem_req = 1 and mem_we = 1 held for 4 cycles; no reg_write; return to FETCH.
- `sub` R-type (funct3 000, funct7_5 1) → alu_control = 001 in EXECR, reg_write in ALUWB; total 4 cycles.
- beq/bne branch cases:
  - `beq` with zero = 1 → pc_write = 1 in BRANCH.
  - `bne` with zero = 1 → pc_write = 0.
  - funct3 = 100 → pc_write = 0.
- `jal`:
  - With MC_CTRL_JAL_EN: states 0, 1, 10, 8, 0 and pc_write = 1 in JAL.
  - Without MC_CTRL_JAL_EN: state = 15 and illegal = 1 until rst_n pulses low.
- rst_n pulled low during a MEMREAD wait → all strobes = 0 immediately; after release, state = 0 and mem_req = 1 with adr_src = 0.
